memory_responder: RTL and testbench
===================================

Name: memory_responder

Overview:
- Memory-side endpoint of the core/memory interconnect: consumes the arbitrated request stream (`mem_req`) and produces the response stream (`mem_rsp`), which the interconnect routes back to cores by `core_id`.
- Holds a word-addressed on-chip memory array. Buffers incoming requests in a small FIFO because the request path has no backpressure.
- Serves writes as single-word writes with a one-beat acknowledge. Serves reads as bursts of `access_length` consecutive words, one beat per cycle.

Parameters:
- MEM_DEPTH, 1024, number of data words in the array; must be a power of two.
- FIFO_DEPTH, 4, request FIFO entries; must be a power of two.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- mem_req  input  request_t  request from the interconnect; sampled when `mem_req.vld`=1
- mem_rsp  output  request_t  registered response to the interconnect; one beat per cycle when `vld`=1
- busy  output  1  high while the FSM is in RD_BURST or the FIFO is non-empty
- fifo_level  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
- overflow  output  1  sticky; set when a request is dropped

Behaviour:
- Reset (reset=0, async): FIFO emptied, FSM to IDLE, `mem_rsp`='0, `busy`=0, `fifo_level`=0, `overflow`=0. Array contents are not reset. Reset mid-burst aborts the burst with no further beats.
- Request fields used: `vld`, `core_id`, `req_type` (REQ_READ/REQ_WRITE), `addr`, `data`, `access_length`.
- Array index: `addr[$clog2(MEM_DEPTH)-1:0]`. Higher bits are ignored.
- Push: every cycle with `mem_req.vld`=1, the whole request is pushed.
  - Full FIFO and no pop that cycle: request dropped, `overflow` set.
  - Full FIFO with a pop in the same cycle: push succeeds, level unchanged.
- FSM states: IDLE, RD_BURST.
- IDLE with FIFO non-empty (at a clock edge): pop the head.
  - REQ_WRITE: `mem[idx]` <= `data`. `mem_rsp` <= head copy with `vld`=1 (write ack). Stay in IDLE.
  - REQ_READ: effective length `L` = `access_length`, or 1 if `access_length`=0. `mem_rsp` <= head copy with `vld`=1, `data`=`mem[idx]`, `addr`=`idx`. If `L`>1: load `remaining`=L-1, `cur_idx`=idx+1, go to RD_BURST; else stay in IDLE.
- IDLE with FIFO empty: `mem_rsp` <= '0.
- RD_BURST, each edge:
  - `mem_rsp` <= {`vld`=1, same `core_id`/`req_type`/`access_length`, `addr`=`cur_idx`, `data`=`mem[cur_idx]`}.
  - `cur_idx`++ with wrap modulo MEM_DEPTH (address MEM_DEPTH-1 is followed by 0).
  - `remaining`--. When `remaining` reaches 0 after this beat, go to IDLE.
  - No pops during RD_BURST; pushes continue.
- Latency: request with `vld` in cycle N is in the FIFO in N+1, popped at the end of N+1, first beat visible in N+2 (empty FIFO, FSM idle).
- Back-to-back: the FSM returns to IDLE after the last beat and pops at the next edge, so consecutive responses have no idle cycle between them.
- Ordering: strict FIFO. A read popped after a write to the same index returns the written data.
- `mem_rsp` is fully registered and has no combinational path from `mem_req`.
- `busy` is combinational from FSM state and FIFO level.

Decomposition:
- Shared package: `request_t` (fields above), `NUM_OF_CORES`, `req_type_e` {REQ_READ, REQ_WRITE}, `rsp_state_e` {IDLE, RD_BURST}.
- Sub-module `sync_fifo` (params WIDTH=$bits(request_t), DEPTH), with ports push, pop, din, dout, full, empty, level, async active-low reset. Reusable elsewhere.
- Array, burst counter and FSM stay in `memory_responder`.

Test Plan:
- Reset mid-burst: read `access_length`=8, assert reset at beat 3 -> `mem_rsp.vld`=0 immediately and stays 0 after release; `fifo_level`=0, `busy`=0.
- Write then read: write core_id=2, addr=0x10, data=0xDEADBEEF; then read core_id=2, addr=0x10, length=1 -> ack beat in N+2 with core_id=2, REQ_WRITE; read beat data=0xDEADBEEF, core_id=2.
- Burst with wrap: preload idx 1022, 1023, 0 with 0xA, 0xB, 0xC; read addr=1022, length=3 -> three consecutive beats with addr 1022, 1023, 0 and data 0xA, 0xB, 0xC, then `vld`=0.
- Zero length: read `access_length`=0 -> exactly one beat returned.
- Overflow: during a length-16 burst, push 5 requests (FIFO_DEPTH=4) -> `fifo_level`=4, `overflow`=1 and sticky, fifth request never answered, first four answered in order.
- Back-to-back mixed: reads from core 0 (len 2), core 3 (len 1), and a write from core 1, issued in consecutive cycles -> four response beats in consecutive cycles with core_id sequence 0, 0, 3, 1.

Source files
------------

// File: rtl/memory_responder_pkg.sv
// Shared types for the memory responder and its clients on the core/memory
// interconnect.
//   request_t   : one request/response beat (vld, core_id, req_type, addr,
//                 data, access_length)
//   req_type_e  : REQ_READ / REQ_WRITE
//   rsp_state_e : responder FSM states
package memory_responder_pkg;

  localparam int NUM_OF_CORES = 4;
  localparam int CORE_ID_W    = $clog2(NUM_OF_CORES);
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int LEN_W        = 8;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_type_e;

  typedef enum logic {
    IDLE     = 1'b0,
    RD_BURST = 1'b1
  } rsp_state_e;

  typedef struct packed {
    logic                 vld;
    logic [CORE_ID_W-1:0] core_id;
    req_type_e            req_type;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    data;
    logic [LEN_W-1:0]     access_length;
  } request_t;

endpackage

// File: rtl/memory_responder_sync_fifo.sv
// Generic synchronous FIFO with show-ahead output.
//   clk, reset : clock, asynchronous active-low reset
//   push, din  : write strobe and data; accepted when not full, or when full
//                and a pop happens in the same cycle
//   pop, dout  : read strobe and head data (dout valid while !empty)
//   full, empty, level : occupancy status
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_LVL);
  assign level   = level_q;
  assign dout    = storage[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= din;
  end

endmodule

// File: rtl/memory_responder.sv
// Memory-side endpoint of the core/memory interconnect. Buffers requests in
// a FIFO (the request path has no backpressure), serves writes with a
// one-beat acknowledge and reads as bursts of access_length words.
//   clk, reset : clock, asynchronous active-low reset
//   mem_req    : incoming request, sampled when mem_req.vld
//   mem_rsp    : registered response beat, valid when mem_rsp.vld
//   busy       : burst in progress or requests pending
//   fifo_level : request FIFO occupancy
//   overflow   : sticky, a request was dropped on a full FIFO
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int MEM_DEPTH  = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  request_t                            mem_req,
  output request_t                            mem_rsp,
  output logic                                busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
  output logic                                overflow
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [DATA_W-1:0]          mem [MEM_DEPTH];

  rsp_state_e                 state_q, state_d;
  request_t                   rsp_q, rsp_d;
  logic [LEN_W-1:0]           remaining_q, remaining_d;
  logic [IDX_W-1:0]           cur_idx_q, cur_idx_d;

  logic [$bits(request_t)-1:0] head_bits;
  request_t                   head;
  logic [IDX_W-1:0]           head_idx;
  logic                       fifo_pop, fifo_full, fifo_empty;

  assign head     = request_t'(head_bits);
  assign head_idx = head.addr[IDX_W-1:0];

  sync_fifo #(
    .WIDTH ($bits(request_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (mem_req.vld),
    .pop   (fifo_pop),
    .din   (mem_req),
    .dout  (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign busy    = (state_q == RD_BURST) || !fifo_empty;
  assign mem_rsp = rsp_q;

  always_comb begin
    state_d     = state_q;
    rsp_d       = '0;
    remaining_d = remaining_q;
    cur_idx_d   = cur_idx_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          rsp_d     = head;
          rsp_d.vld = 1'b1;
          if (head.req_type == REQ_READ) begin
            rsp_d.data = mem[head_idx];
            rsp_d.addr = ADDR_W'(head_idx);
            // access_length of 0 or 1 both mean a single beat
            if (head.access_length > LEN_W'(1)) begin
              remaining_d = head.access_length - 1'b1;
              cur_idx_d   = head_idx + 1'b1;
              state_d     = RD_BURST;
            end
          end
        end
      end
      RD_BURST: begin
        // core_id/req_type/access_length carry over from the previous beat
        rsp_d       = rsp_q;
        rsp_d.vld   = 1'b1;
        rsp_d.addr  = ADDR_W'(cur_idx_q);
        rsp_d.data  = mem[cur_idx_q];
        cur_idx_d   = cur_idx_q + 1'b1;
        remaining_d = remaining_q - 1'b1;
        if (remaining_q == LEN_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rsp_q       <= '0;
      remaining_q <= '0;
      cur_idx_q   <= '0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_q       <= rsp_d;
      remaining_q <= remaining_d;
      cur_idx_q   <= cur_idx_d;
      if (mem_req.vld && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_pop && head.req_type == REQ_WRITE) mem[head_idx] <= head.data;
  end

endmodule

// File: tb/tb_memory_responder.sv
module tb_memory_responder;
  import memory_responder_pkg::*;

  logic     clk = 1'b0;
  logic     reset;
  request_t mem_req, mem_rsp;
  logic     busy;
  logic [2:0] fifo_level;
  logic     overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  memory_responder #(
    .MEM_DEPTH  (1024),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_rsp    (mem_rsp),
    .busy       (busy),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  core;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  len;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic request_t mk(input logic wr, input logic [1:0] core,
                                  input logic [31:0] addr, input logic [31:0] data,
                                  input logic [7:0] len);
    request_t r;
    r               = '0;
    r.vld           = 1'b1;
    r.core_id       = core;
    r.req_type      = wr ? REQ_WRITE : REQ_READ;
    r.addr          = addr;
    r.data          = data;
    r.access_length = len;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [1:0] core, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data, input logic use_data);
    chk({tag, ".vld"}, 64'(mem_rsp.vld), 64'd1);
    chk({tag, ".core"}, 64'(mem_rsp.core_id), 64'(core));
    chk({tag, ".type"}, 64'(mem_rsp.req_type), 64'(wr));
    chk({tag, ".addr"}, 64'(mem_rsp.addr), 64'(addr));
    if (use_data) chk({tag, ".data"}, 64'(mem_rsp.data), 64'(data));
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while ((busy || mem_rsp.vld) && n < 100) begin
      step();
      n++;
    end
    chk(name, 64'(busy || mem_rsp.vld), 64'd0);
  endtask

  vec_t        vecs[5];
  logic [31:0] wa[3];
  logic [31:0] wd[3];
  logic [31:0] q_addr[$];
  logic [1:0]  q_core[$];
  logic        q_wr[$];
  logic [31:0] q_data[$];

  initial begin
    vecs[0] = '{1'b1, 2'd2, 32'h0000_0010, 32'hDEAD_BEEF, 8'd1, 32'h0000_0010, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 2'd2, 32'h0000_0010, 32'h0,         8'd1, 32'h0000_0010, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 2'd1, 32'h0000_0405, 32'h0000_1234, 8'd1, 32'h0000_0405, 32'h0000_1234};
    vecs[3] = '{1'b0, 2'd3, 32'h0000_0005, 32'h0,         8'd0, 32'h0000_0005, 32'h0000_1234};
    vecs[4] = '{1'b0, 2'd0, 32'hFFFF_0010, 32'h0,         8'd1, 32'h0000_0010, 32'hDEAD_BEEF};
    wa[0] = 32'd1022; wa[1] = 32'd1023; wa[2] = 32'd0;
    wd[0] = 32'hA;    wd[1] = 32'hB;    wd[2] = 32'hC;

    mem_req = '0;
    reset   = 1'b0;
    step();
    step();
    chk("rst.rsp", 64'(mem_rsp), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.level", 64'(fifo_level), 64'd0);
    chk("rst.overflow", 64'(overflow), 64'd0);
    reset = 1'b1;
    step();

    // single-transaction vectors: beat appears two edges after the request
    for (int i = 0; i < 5; i++) begin
      mem_req = mk(vecs[i].wr, vecs[i].core, vecs[i].addr, vecs[i].data, vecs[i].len);
      step();
      mem_req = '0;
      chk($sformatf("v%0d.level", i), 64'(fifo_level), 64'd1);
      chk($sformatf("v%0d.early", i), 64'(mem_rsp.vld), 64'd0);
      step();
      chk_beat($sformatf("v%0d", i), vecs[i].core, vecs[i].wr, vecs[i].exp_addr, vecs[i].exp_data, 1'b1);
      chk($sformatf("v%0d.len", i), 64'(mem_rsp.access_length), 64'(vecs[i].len));
      step();
      chk($sformatf("v%0d.after", i), 64'(mem_rsp.vld), 64'd0);
      chk($sformatf("v%0d.busy", i), 64'(busy), 64'd0);
    end

    // burst wrapping past the top of the array
    for (int k = 0; k < 3; k++) begin
      mem_req = mk(1'b1, 2'd0, wa[k], wd[k], 8'd1);
      step();
    end
    mem_req = '0;
    wait_quiet("wrap.preload_quiet");
    mem_req = mk(1'b0, 2'd1, 32'd1022, 32'd0, 8'd3);
    step();
    mem_req = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_beat($sformatf("wrap%0d", k), 2'd1, 1'b0, wa[k], wd[k], 1'b1);
    end
    step();
    chk("wrap.end", 64'(mem_rsp.vld), 64'd0);

    // back-to-back mixed requests: no idle cycle between responses
    mem_req = mk(1'b0, 2'd0, 32'h10, 32'd0, 8'd2);
    step();
    mem_req = mk(1'b0, 2'd3, 32'h5, 32'd0, 8'd1);
    step();
    chk_beat("b2b0", 2'd0, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1);
    mem_req = mk(1'b1, 2'd1, 32'h7, 32'h77, 8'd1);
    step();
    mem_req = '0;
    chk_beat("b2b1", 2'd0, 1'b0, 32'h11, 32'd0, 1'b0);
    step();
    chk_beat("b2b2", 2'd3, 1'b0, 32'h5, 32'h1234, 1'b1);
    step();
    chk_beat("b2b3", 2'd1, 1'b1, 32'h7, 32'h77, 1'b1);
    step();
    chk("b2b.end", 64'(mem_rsp.vld), 64'd0);

    // overflow: five writes queued behind a 16-beat burst, fifth is dropped
    for (int c = 0; c < 40; c++) begin
      if (c == 0)
        mem_req = mk(1'b0, 2'd2, 32'd0, 32'd0, 8'd16);
      else if (c >= 2 && c <= 6)
        mem_req = mk(1'b1, 2'(c - 2), 32'(200 + c - 2), 32'(32'h100 + c), 8'd1);
      else
        mem_req = '0;
      step();
      if (c == 6) begin
        chk("ovf.level", 64'(fifo_level), 64'd4);
        chk("ovf.flag", 64'(overflow), 64'd1);
        chk("ovf.busy", 64'(busy), 64'd1);
      end
      if (mem_rsp.vld) begin
        q_addr.push_back(mem_rsp.addr);
        q_core.push_back(mem_rsp.core_id);
        q_wr.push_back(mem_rsp.req_type == REQ_WRITE);
        q_data.push_back(mem_rsp.data);
      end
    end
    chk("ovf.beats", 64'(q_addr.size()), 64'd20);
    if (q_addr.size() == 20) begin
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("ovf.rd%0d.addr", i), 64'(q_addr[i]), 64'(i));
        chk($sformatf("ovf.rd%0d.type", i), 64'(q_wr[i]), 64'd0);
      end
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("ovf.wr%0d.addr", j), 64'(q_addr[16+j]), 64'(200 + j));
        chk($sformatf("ovf.wr%0d.core", j), 64'(q_core[16+j]), 64'(j));
        chk($sformatf("ovf.wr%0d.data", j), 64'(q_data[16+j]), 64'(32'h102 + j));
      end
    end
    chk("ovf.sticky", 64'(overflow), 64'd1);
    chk("ovf.drained", 64'(fifo_level), 64'd0);

    // reset in the middle of a burst
    mem_req = mk(1'b0, 2'd1, 32'd0, 32'd0, 8'd8);
    step();
    mem_req = '0;
    step();
    step();
    step();
    chk_beat("mid.beat3", 2'd1, 1'b0, 32'd2, 32'd0, 1'b0);
    reset = 1'b0;
    #1;
    chk("mid.vld", 64'(mem_rsp.vld), 64'd0);
    chk("mid.busy", 64'(busy), 64'd0);
    chk("mid.level", 64'(fifo_level), 64'd0);
    chk("mid.overflow", 64'(overflow), 64'd0);
    step();
    step();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("mid.post%0d", k), 64'(mem_rsp.vld || busy), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
